boot_loader: RTL and testbench

Memory-port sequencer that sits between the multi-cycle processor and system memory. It holds the processor in reset, accepts a length-prefixed program image over a valid/ready word stream, and writes the image into memory through the single shared port. It then releases the processor and passes its memory accesses straight through. A later `start` pulse reloads the image.

---
 rtl/boot_loader_pkg.sv | 33 +++
 rtl/boot_loader_if.sv | 19 +
 rtl/boot_loader.sv | 160 ++++++++++++++++
 tb/tb_boot_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and sizing for the boot loader.
//   state_t  - loader FSM state encoding. The CHK and ERR states exist only
//              when BOOT_LOADER_CHECKSUM_EN is defined.
//   DEF_*    - default address/data widths.
//   CNT_W    - width of the word counter and the latched length N.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
package boot_loader_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned CNT_W      = DEF_DATA_W;

`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_FLUSH,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN
  } state_t;
`endif

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: valid/ready word stream carrying the program image.
//   in_valid - producer has a word on in_data
//   in_data  - stream word, DATA_W bits
//   in_ready - loader accepts in_data this cycle
// Modports: master (image source), slave (boot_loader).
interface boot_loader_if
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/boot_loader.sv
// boot_loader: memory-port sequencer between the processor and memory.
// Holds the processor in reset, takes a length-prefixed image from the word
// stream, writes it from BASE_ADDR upward through the shared memory port,
// then releases the processor and passes its accesses straight through.
// A start pulse in IDLE/RUN (and ERR) reloads the image.
// Ports:
//   clk, rst (async active-low), start
//   stream   - image word stream (boot_loader_if.slave)
//   cpu_rst  - active-high processor reset (registered)
//   cpu_addr, cpu_wd, cpu_we, cpu_rd - processor memory port
//   mem_addr, mem_wd, mem_we, mem_rd - system memory port
//   done     - high while running; err - high after checksum mismatch
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (trailing checksum word,
// CHK/ERR states). Without it err is tied low.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  boot_loader_if.slave      stream,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic              rdy;
  logic              hs;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_pend;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign hs              = stream.in_valid & rdy;
  assign stream.in_ready = rdy;
  assign cpu_rd          = mem_rd;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        rdy = 1'b1;
        if (hs) state_nxt = (CNT_W'(stream.in_data) != '0) ? ST_LOAD : ST_FLUSH;
      end
      ST_LOAD: begin
        rdy = 1'b1;
        if (hs && (cnt == n - CNT_W'(1))) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        state_nxt = ST_CHK;
`else
        state_nxt = ST_RUN;
`endif
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHK: begin
        rdy = 1'b1;
        if (hs) state_nxt = (stream.in_data == sum) ? ST_RUN : ST_ERR;
      end
      ST_ERR: begin
        if (start) state_nxt = ST_HDR;
      end
`endif
      ST_RUN: begin
        if (start) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they switch on
  // the same edge that enters or leaves the corresponding state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_rst <= (state_nxt != ST_RUN);
      done    <= (state_nxt == ST_RUN);
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= (state_nxt == ST_ERR);
  end
`else
  assign err = 1'b0;
`endif

  // Write pipeline: a word accepted at edge k is presented to memory for
  // the following cycle and retires at edge k+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n       <= '0;
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_pend <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      wr_pend <= 1'b0;
      if (state == ST_HDR && hs) begin
        n   <= CNT_W'(stream.in_data);
        cnt <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum <= stream.in_data;
`endif
      end
      if (state == ST_LOAD && hs) begin
        wr_addr <= BASE_ADDR + ADDR_W'(cnt);
        wr_data <= stream.in_data;
        wr_pend <= 1'b1;
        cnt     <= cnt + CNT_W'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum     <= sum + stream.in_data;
`endif
      end
    end
  end

  always_comb begin
    mem_addr = wr_addr;
    mem_wd   = wr_data;
    mem_we   = wr_pend;
    if (state == ST_RUN) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      mem_we   = cpu_we;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed, self-checking bench for boot_loader.
// Two instances share all stimulus: dut0 with BASE_ADDR 0x0000 and dut1 with
// BASE_ADDR 0xFFFE (address wrap). Build with BOOT_LOADER_CHECKSUM_EN to
// cover the checksum states.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [15:0] data, cpu_addr, cpu_wd, mem_rd;
  logic        cpu_we;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boot_loader_if #(.DATA_W(16)) s0 ();
  boot_loader_if #(.DATA_W(16)) s1 ();
  assign s0.in_valid = valid;
  assign s0.in_data  = data;
  assign s1.in_valid = valid;
  assign s1.in_data  = data;

  logic        cpu_rst0, mem_we0, done0, err0;
  logic [15:0] cpu_rd0, mem_addr0, mem_wd0;
  logic        cpu_rst1, mem_we1, done1, err1;
  logic [15:0] cpu_rd1, mem_addr1, mem_wd1;

  boot_loader #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stream(s0.slave),
    .cpu_rst(cpu_rst0), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
    .cpu_rd(cpu_rd0), .mem_addr(mem_addr0), .mem_wd(mem_wd0), .mem_we(mem_we0),
    .mem_rd(mem_rd), .done(done0), .err(err0));

  boot_loader #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stream(s1.slave),
    .cpu_rst(cpu_rst1), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
    .cpu_rd(cpu_rd1), .mem_addr(mem_addr1), .mem_wd(mem_wd1), .mem_we(mem_we1),
    .mem_rd(mem_rd), .done(done1), .err(err1));

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam int unsigned XTRA = 1;
`else
  localparam int unsigned XTRA = 0;
`endif

  // Loader-side memory writes (processor held in reset), one entry per cycle.
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned cyc;
  } wr_t;
  wr_t log0[$];
  wr_t log1[$];

  always @(negedge clk) begin
    if (rst && cpu_rst0 && mem_we0) log0.push_back(wr_t'{addr: mem_addr0, data: mem_wd0, cyc: cyc});
    if (rst && cpu_rst1 && mem_we1) log1.push_back(wr_t'{addr: mem_addr1, data: mem_wd1, cyc: cyc});
  end

  int nchk  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int unsigned last_hs, hdr_edge, run_edge, first_hs;
  logic [15:0] img[$];

  // Present one word; returns just after the edge on which it was accepted.
  task automatic send(input logic [15:0] w, input bit gap);
    if (gap) begin
      valid = 1'b0;
      data  = 16'hDEAD;
      @(posedge clk); #1;
    end
    valid = 1'b1;
    data  = w;
    for (int t = 0; t < 20; t++) begin
      if (s0.in_ready) begin
        @(posedge clk); #1;
        last_hs = cyc;
        valid   = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    nchk++;
    nfail++;
    $display("FAIL send_timeout: word 0x%0h not accepted within 20 cycles", w);
    valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    hdr_edge = cyc;
  endtask

  // Stream img (header first), then the checksum word when that build is on.
  task automatic load_image(input bit gap, input logic [15:0] csum);
    log0.delete();
    log1.delete();
    first_hs = 0;
    for (int i = 0; i < img.size(); i++) begin
      send(img[i], gap);
      if (i == 1) first_hs = last_hs;
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(csum, gap);
`else
    if (csum != 16'h0) first_hs = first_hs + 0;
`endif
  endtask

  // Wait for RUN or ERR; run_edge is the edge that entered it.
  task automatic wait_settle(input string name);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done0 || err0) begin
        run_edge = cyc;
        return;
      end
    end
    nchk++;
    nfail++;
    $display("FAIL %s_timeout: done/err not seen within 30 cycles", name);
    run_edge = 0;
  endtask

  typedef struct {
    logic [15:0] a, wd;
    logic        we;
    logic [15:0] rd;
    logic [15:0] ea, ewd;
    logic        ewe;
    logic [15:0] erd;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{16'h0010, 16'h1234, 1'b1, 16'h0F0F, 16'h0010, 16'h1234, 1'b1, 16'h0F0F};
    tbl[1] = '{16'hABCD, 16'h5555, 1'b0, 16'h1111, 16'hABCD, 16'h5555, 1'b0, 16'h1111};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};
    tbl[3] = '{16'h0010, 16'h1234, 1'b1, 16'h2468, 16'h0010, 16'h1234, 1'b1, 16'h2468};

    rst = 1'b0; start = 1'b0; valid = 1'b0; data = 16'h0;
    cpu_addr = 16'h0; cpu_wd = 16'h0; cpu_we = 1'b0; mem_rd = 16'h5A5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", cpu_rst0, 1);
    check("rst_in_ready", s0.in_ready, 0);
    check("rst_mem_we", mem_we0, 0);
    check("rst_mem_addr", mem_addr0, 16'h0000);
    check("rst_mem_wd", mem_wd0, 16'h0000);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_mem_addr_b", mem_addr1, 16'h0000);
    check("rst_cpu_rd", cpu_rd0, 16'h5A5A);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", s0.in_ready, 0);

    // Back-to-back load of 3 words
    do_start();
    img = '{16'd3, 16'hA001, 16'hA002, 16'hA003};
    load_image(1'b0, 16'hE009);
    wait_settle("loadA");
    check("loadA_latency", run_edge - hdr_edge, 5 + XTRA);
    check("loadA_done", done0, 1);
    check("loadA_cpu_rst", cpu_rst0, 0);
    check("loadA_err", err0, 0);
    check("loadA_nwr", log0.size(), 3);
    check("loadA_nwr_b", log1.size(), 3);
    if (log0.size() == 3) begin
      check("loadA_a0", log0[0].addr, 16'h0000);
      check("loadA_d0", log0[0].data, 16'hA001);
      check("loadA_a1", log0[1].addr, 16'h0001);
      check("loadA_d1", log0[1].data, 16'hA002);
      check("loadA_a2", log0[2].addr, 16'h0002);
      check("loadA_d2", log0[2].data, 16'hA003);
      check("loadA_lat", log0[0].cyc, first_hs);
      check("loadA_c1", log0[1].cyc, first_hs + 1);
      check("loadA_c2", log0[2].cyc, first_hs + 2);
    end
    if (log1.size() == 3) begin
      check("wrap_a0", log1[0].addr, 16'hFFFE);
      check("wrap_a1", log1[1].addr, 16'hFFFF);
      check("wrap_a2", log1[2].addr, 16'h0000);
      check("wrap_d2", log1[2].data, 16'hA003);
    end

    // Pass-through vectors in RUN
    for (int i = 0; i < 4; i++) begin
      cpu_addr = tbl[i].a;
      cpu_wd   = tbl[i].wd;
      cpu_we   = tbl[i].we;
      mem_rd   = tbl[i].rd;
      @(negedge clk);
      check($sformatf("run%0d_addr", i), mem_addr0, tbl[i].ea);
      check($sformatf("run%0d_wd", i), mem_wd0, tbl[i].ewd);
      check($sformatf("run%0d_we", i), mem_we0, tbl[i].ewe);
      check($sformatf("run%0d_rd", i), cpu_rd0, tbl[i].erd);
      @(posedge clk); #1;
    end

    // start in RUN: back to HDR, processor write ignored on the same edge
    do_start();
    check("restart_cpu_rst", cpu_rst0, 1);
    check("restart_done", done0, 0);
    check("restart_mem_we", mem_we0, 0);
    check("restart_mem_addr", mem_addr0, 16'h0002);
    check("restart_mem_wd", mem_wd0, 16'hA003);
    check("restart_mem_addr_b", mem_addr1, 16'h0000);
    check("restart_in_ready", s0.in_ready, 1);
    cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wd = 16'h0;

    // 4-word load with in_valid toggling
    img = '{16'd4, 16'hB000, 16'hB001, 16'hB002, 16'hB003};
    load_image(1'b1, 16'hC00A);
    wait_settle("loadB");
    check("loadB_done", done0, 1);
    check("loadB_nwr", log0.size(), 4);
    if (log0.size() == 4) begin
      check("loadB_a0", log0[0].addr, 16'h0000);
      check("loadB_a1", log0[1].addr, 16'h0001);
      check("loadB_a2", log0[2].addr, 16'h0002);
      check("loadB_a3", log0[3].addr, 16'h0003);
      check("loadB_d0", log0[0].data, 16'hB000);
      check("loadB_d3", log0[3].data, 16'hB003);
    end

    // Empty image
    do_start();
    img = '{16'd0};
    load_image(1'b0, 16'h0000);
    wait_settle("loadZ");
    check("loadZ_latency", run_edge - hdr_edge, 2 + XTRA);
    check("loadZ_nwr", log0.size(), 0);
    check("loadZ_done", done0, 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_start();
    img = '{16'd2, 16'h0001, 16'h0002};
    load_image(1'b0, 16'h0005);
    wait_settle("csum_ok");
    check("csum_ok_done", done0, 1);
    check("csum_ok_err", err0, 0);
    do_start();
    load_image(1'b0, 16'h0006);
    wait_settle("csum_bad");
    check("csum_bad_err", err0, 1);
    check("csum_bad_cpu_rst", cpu_rst0, 1);
    check("csum_bad_done", done0, 0);
    check("csum_bad_in_ready", s0.in_ready, 0);
    do_start();
    check("err_clear", err0, 0);
    check("err_to_hdr", s0.in_ready, 1);
`else
    do_start();
`endif

    // Asynchronous reset in the middle of LOAD
    log0.delete();
    send(16'd5, 1'b0);
    send(16'hC000, 1'b0);
    send(16'hC001, 1'b0);
    valid = 1'b1;
    data  = 16'hC002;
    check("midload_pend", mem_we0, 1);
    #2 rst = 1'b0;
    #1;
    check("midload_mem_we", mem_we0, 0);
    check("midload_cpu_rst", cpu_rst0, 1);
    check("midload_in_ready", s0.in_ready, 0);
    check("midload_mem_addr", mem_addr0, 16'h0000);
    check("midload_nwr", log0.size(), 1);
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_idle", s0.in_ready, 0);
    check("after_rst_done", done0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
